spram_bus_arb: RTL and testbench

- Two-master front end for the on-chip SPRAM word store (2x SB_SPRAM256KA, 16K x 32, byte-maskable, 1-cycle read latency).
- Muxes the PicoRV32 native memory bus and an audio delay-line DMA port onto the single SPRAM port.
- Owns all SPRAM timing: registered address/data/mask, read-data capture, ready handshakes.
- Round-robin arbitration so neither master starves.

---
 rtl/spram_bus_arb.sv | 170 +++++++++++++++++
 tb/tb_spram_bus_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_bus_arb.sv
// spram_bus_arb: two-master (CPU / audio DMA) front end for the SPRAM word store.
// One access at a time through a fixed IDLE -> ISSUE -> WAIT -> RESP sequence;
// round-robin between masters when both request in the same cycle.
module spram_bus_arb #(
    parameter int ADDR_WIDTH    = 14,
    parameter int RAM_ADDR_PORT = 22
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    input  logic [31:0]              cpu_addr,
    input  logic [31:0]              cpu_wdata,
    input  logic [3:0]               cpu_wstrb,
    output logic [31:0]              cpu_rdata,
    input  logic                     dma_valid,
    output logic                     dma_ready,
    input  logic                     dma_we,
    input  logic [ADDR_WIDTH-1:0]    dma_addr,
    input  logic [31:0]              dma_wdata,
    output logic [31:0]              dma_rdata,
    output logic [3:0]               ram_wen,
    output logic [RAM_ADDR_PORT-1:0] ram_addr,
    output logic [31:0]              ram_wdata,
    input  logic [31:0]              ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_owner_q, last_owner_d;
    logic                    is_read_q, is_read_d;
    logic [3:0]              ram_wen_q, ram_wen_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]             ram_wdata_q, ram_wdata_d;
    logic                    cpu_ready_q, cpu_ready_d;
    logic                    dma_ready_q, dma_ready_d;
    logic [31:0]             cpu_rdata_q, cpu_rdata_d;
    logic [31:0]             dma_rdata_q, dma_rdata_d;
    logic                    grant_dma_s;

    // Byte-offset bits and bits above the SPRAM size are deliberately ignored;
    // dropping the high bits is what makes oversized CPU addresses alias.
    logic cpu_addr_unused_s;
    assign cpu_addr_unused_s = ^{cpu_addr[31:ADDR_WIDTH+2], cpu_addr[1:0]};

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        is_read_d    = is_read_q;
        ram_wen_d    = ram_wen_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        cpu_ready_d  = cpu_ready_q;
        dma_ready_d  = dma_ready_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        grant_dma_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // DMA wins a conflict only when the CPU was served last.
                grant_dma_s = dma_valid && (!cpu_valid || (last_owner_q == OWN_CPU));
                if (cpu_valid || dma_valid) begin
                    state_d = S_ISSUE;
                    if (grant_dma_s) begin
                        owner_d     = OWN_DMA;
                        ram_addr_d  = dma_addr;
                        ram_wdata_d = dma_wdata;
                        ram_wen_d   = dma_we ? 4'b1111 : 4'b0000;
                        is_read_d   = !dma_we;
                    end else begin
                        owner_d     = OWN_CPU;
                        ram_addr_d  = cpu_addr[ADDR_WIDTH+1:2];
                        ram_wdata_d = cpu_wdata;
                        ram_wen_d   = cpu_wstrb;
                        is_read_d   = (cpu_wstrb == 4'b0000);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                // SPRAM samples address/data/enables at the end of this cycle.
                ram_wen_d = 4'b0000;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Read data is valid now; only the owner's view is updated.
                if (owner_q == OWN_DMA) begin
                    dma_ready_d = 1'b1;
                    if (is_read_q) begin
                        dma_rdata_d = ram_rdata;
                    end else begin
                        dma_rdata_d = dma_rdata_q;
                    end
                end else begin
                    cpu_ready_d = 1'b1;
                    if (is_read_q) begin
                        cpu_rdata_d = ram_rdata;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                cpu_ready_d  = 1'b0;
                dma_ready_d  = 1'b0;
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: begin
                ram_wen_d   = 4'b0000;
                cpu_ready_d = 1'b0;
                dma_ready_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_CPU;
            is_read_q    <= 1'b0;
            ram_wen_q    <= 4'b0000;
            ram_addr_q   <= {ADDR_WIDTH{1'b0}};
            ram_wdata_q  <= 32'h0000_0000;
            cpu_ready_q  <= 1'b0;
            dma_ready_q  <= 1'b0;
            cpu_rdata_q  <= 32'h0000_0000;
            dma_rdata_q  <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            is_read_q    <= is_read_d;
            ram_wen_q    <= ram_wen_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            cpu_ready_q  <= cpu_ready_d;
            dma_ready_q  <= dma_ready_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign dma_ready = dma_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign ram_wen   = ram_wen_q;
    assign ram_addr  = {{(RAM_ADDR_PORT-ADDR_WIDTH){1'b0}}, ram_addr_q};
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_spram_bus_arb.sv
// Scoreboard bench for spram_bus_arb: a transaction-level model predicts grant
// order, ready cycle, read data and SPRAM writes; a monitor checks the DUT.
module tb_spram_bus_arb;
    localparam int AW  = 14;
    localparam int RAP = 22;

    logic            clk = 1'b0;
    logic            resetn;
    logic            cpu_valid, cpu_ready, dma_valid, dma_ready, dma_we;
    logic [31:0]     cpu_addr, cpu_wdata, cpu_rdata, dma_wdata, dma_rdata;
    logic [3:0]      cpu_wstrb, ram_wen;
    logic [AW-1:0]   dma_addr;
    logic [RAP-1:0]  ram_addr;
    logic [31:0]     ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    spram_bus_arb #(.ADDR_WIDTH(AW), .RAM_ADDR_PORT(RAP)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rdata(dma_rdata),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // SPRAM behaviour: byte-masked write, registered read with 1-cycle latency.
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wen[b]) mem[ram_addr[13:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr[13:0]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct { bit dma; logic [31:0] data; logic [31:0] other; int cyc; } resp_t;
    typedef struct { logic [21:0] addr; logic [3:0] wen; logic [31:0] wdata; int cyc; } wr_t;

    logic [31:0] ref_mem [0:16383];
    resp_t       rq[$];
    wr_t         wq[$];
    bit          last_dma;
    logic [31:0] m_cpu_rd, m_dma_rd;
    int          last_ready;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        last_dma   = 1'b0;
        m_cpu_rd   = 32'h0;
        m_dma_rd   = 32'h0;
        last_ready = -100;
        rq.delete();
        wq.delete();
    endtask

    task automatic model_access(input bit dma, input int word, input logic [31:0] wd,
                                input logic [3:0] wen, input int rcyc);
        resp_t r;
        wr_t   w;
        logic [31:0] m;
        r.other = dma ? m_cpu_rd : m_dma_rd;
        if (wen != 4'b0000) begin
            w.addr = 22'(word); w.wen = wen; w.wdata = wd; w.cyc = rcyc - 2;
            wq.push_back(w);
            m = ref_mem[word];
            for (int b = 0; b < 4; b++) if (wen[b]) m[8*b +: 8] = wd[8*b +: 8];
            ref_mem[word] = m;
            r.data = dma ? m_dma_rd : m_cpu_rd;
        end else begin
            r.data = ref_mem[word];
            if (dma) m_dma_rd = r.data; else m_cpu_rd = r.data;
        end
        r.dma = dma; r.cyc = rcyc;
        rq.push_back(r);
        last_dma   = dma;
        last_ready = rcyc;
    endtask

    // Monitor: every write enable and every ready pulse must match the model.
    always @(negedge clk) begin : monitor
        wr_t   w;
        resp_t r;
        if (ram_wen !== 4'b0000) begin
            if (wq.size() == 0) chk("spurious_write", 64'd1, 64'd0);
            else begin
                w = wq.pop_front();
                chk("wr_addr", 64'(ram_addr), 64'(w.addr));
                chk("wr_wen", 64'(ram_wen), 64'(w.wen));
                chk("wr_data", 64'(ram_wdata), 64'(w.wdata));
                chk("wr_cycle", 64'(cyc), 64'(w.cyc));
            end
        end
        if (cpu_ready === 1'b1 || dma_ready === 1'b1) begin
            if (rq.size() == 0) chk("spurious_ready", 64'd1, 64'd0);
            else begin
                r = rq.pop_front();
                chk("grant_is_dma", 64'(dma_ready), 64'(r.dma));
                chk("both_ready", 64'(cpu_ready & dma_ready), 64'd0);
                chk("owner_rdata", 64'(r.dma ? dma_rdata : cpu_rdata), 64'(r.data));
                chk("other_rdata", 64'(r.dma ? cpu_rdata : dma_rdata), 64'(r.other));
                chk("ready_cycle", 64'(cyc), 64'(r.cyc));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; presents the request(s), predicts, waits for completion.
    task automatic issue(input bit dc, input bit dd, input logic [31:0] ca,
                         input logic [31:0] cw, input logic [3:0] cs,
                         input logic [13:0] da, input bit dwe, input logic [31:0] dw);
        int eff;
        cpu_valid = dc; cpu_addr = ca; cpu_wdata = cw; cpu_wstrb = cs;
        dma_valid = dd; dma_addr = da; dma_we = dwe; dma_wdata = dw;
        eff = cyc;
        if (last_ready + 1 > eff) eff = last_ready + 1;
        if (dc && dd) begin
            if (!last_dma) begin
                model_access(1'b1, int'(da), dw, dwe ? 4'hF : 4'h0, eff + 3);
                model_access(1'b0, int'(ca[15:2]), cw, cs, eff + 7);
            end else begin
                model_access(1'b0, int'(ca[15:2]), cw, cs, eff + 3);
                model_access(1'b1, int'(da), dw, dwe ? 4'hF : 4'h0, eff + 7);
            end
        end else if (dc) begin
            model_access(1'b0, int'(ca[15:2]), cw, cs, eff + 3);
        end else begin
            model_access(1'b1, int'(da), dw, dwe ? 4'hF : 4'h0, eff + 3);
        end
        for (int k = 0; k < 20 && (cpu_valid || dma_valid); k++) begin
            @(negedge clk);
            if (cpu_ready) cpu_valid = 1'b0;
            if (dma_ready) dma_valid = 1'b0;
        end
        chk("ready_timeout", 64'(cpu_valid | dma_valid), 64'd0);
        cpu_valid = 1'b0;
        dma_valid = 1'b0;
    endtask

    task automatic cpu_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        issue(1'b1, 1'b0, a, d, s, 14'h0, 1'b0, 32'h0);
    endtask

    task automatic dma_op(input logic [13:0] a, input bit we, input logic [31:0] d);
        issue(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, a, we, d);
    endtask

    task automatic check_reset_outputs();
        chk("rst_cpu_ready", 64'(cpu_ready), 64'd0);
        chk("rst_dma_ready", 64'(dma_ready), 64'd0);
        chk("rst_ram_wen", 64'(ram_wen), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst_dma_rdata", 64'(dma_rdata), 64'd0);
    endtask

    initial begin
        logic [31:0] ca;
        int          mode;
        resetn = 1'b0;
        cpu_valid = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
        dma_valid = 1'b0; dma_addr = 14'h0; dma_we = 1'b0; dma_wdata = 32'h0;
        for (int i = 0; i < 16384; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        resetn = 1'b1;
        @(negedge clk);

        // Contending pairs straight after reset: DMA, CPU, DMA, CPU, ...
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 1'b1, {16'($urandom), 11'h0, 3'($urandom), 2'b00}, $urandom,
                  4'($urandom), 14'($urandom_range(0, 7)), 1'($urandom), $urandom);
        end
        @(negedge clk);

        // Full write / read, byte-masked merge, DMA write then aliased CPU read.
        cpu_op(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
        cpu_op(32'h0000_0010, 32'h0, 4'b0000);
        cpu_op(32'h0000_0020, 32'h1122_3344, 4'b1111);
        cpu_op(32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
        cpu_op(32'h0000_0020, 32'h0, 4'b0000);
        dma_op(14'h3FFF, 1'b1, 32'h0000_7FFF);
        cpu_op(32'h0001_FFFC, 32'h0, 4'b0000);

        // Back-to-back reads with valid held across the ready edge.
        cpu_op(32'h0000_0000, 32'h0, 4'b0000);
        cpu_op(32'h0000_0004, 32'h0, 4'b0000);
        repeat (2) @(negedge clk);

        // Reset during WAIT of a CPU read: aborted, no ready afterwards.
        cpu_valid = 1'b1; cpu_addr = 32'h0000_0010; cpu_wstrb = 4'h0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_reset_outputs();
        cpu_valid = 1'b0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_ready", 64'(cpu_ready | dma_ready), 64'd0);
        end
        resetn = 1'b1;
        @(negedge clk);
        cpu_op(32'h0000_0010, 32'h0, 4'b0000);

        // Randomised mix of single and contending requests.
        for (int i = 0; i < 200; i++) begin
            mode = $urandom_range(1, 3);
            ca = {16'($urandom), 10'h0, 4'($urandom), 2'($urandom)};
            if ($urandom_range(0, 9) == 0) ca[15:2] = 14'h3FFF;
            issue(mode[0], mode[1], ca, $urandom, 4'($urandom),
                  ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15)),
                  1'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("resp_queue_empty", 64'(rq.size()), 64'd0);
        chk("write_queue_empty", 64'(wq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
